// File: rtl/sram_write_fifo.sv
// sram_write_fifo: single-clock write-posting FIFO between a 50MHz CPU write
// port (phase-qualified on clk100) and the SRAM arbiter. Each entry holds a
// 17-bit VRAM address and an 8-bit data byte. Writes arriving while full are
// dropped and flagged in a sticky overflow bit.
//
// Optional feature macro: SRAM_WRFIFO_DROPCNT_EN
//   defined   -> drop_count is a saturating 16-bit count of dropped writes
//   undefined -> drop_count is tied to zero and no counter is built
module sram_write_fifo #(
   parameter int unsigned DEPTH_LOG2 = 9
) (
   input  logic                  clk100,
   input  logic                  reset,
   input  logic                  cpu_we,
   input  logic                  cpu_phase,
   input  logic [16:0]           cpu_addr,
   input  logic [7:0]            cpu_data,
   output logic                  cpu_full,
   input  logic                  rd_en,
   output logic [16:0]           rd_addr,
   output logic [7:0]            rd_data,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  overflow,
   input  logic                  overflow_clr,
   output logic [15:0]           drop_count
);

   localparam int unsigned ADDR_W  = 17;
   localparam int unsigned DATA_W  = 8;
   localparam int unsigned ENTRY_W = ADDR_W + DATA_W;
   localparam int unsigned PTR_W   = DEPTH_LOG2 + 1;
   localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
   localparam int unsigned CNT_W   = 16;

   // Entry storage; contents are never reset, only the pointers are
   logic [ENTRY_W-1:0]  r_mem [DEPTH];

   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [ADDR_W-1:0]   r_rd_addr;
   logic [DATA_W-1:0]   r_rd_data;
   logic                r_overflow;

   logic                w_full;
   logic                w_empty;
   logic                w_wr_req;
   logic                w_push;
   logic                w_drop;
   logic                w_pop;
   logic [DEPTH_LOG2-1:0] w_wr_idx;
   logic [DEPTH_LOG2-1:0] w_rd_idx;
   logic [ENTRY_W-1:0]  w_head;

   // Status and transfer qualifiers, all derived from the registered pointers
   always_comb begin
      w_wr_idx = r_wr_ptr[DEPTH_LOG2-1:0];
      w_rd_idx = r_rd_ptr[DEPTH_LOG2-1:0];
      w_empty  = (r_wr_ptr == r_rd_ptr);
      w_full   = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) &&
                 (w_wr_idx == w_rd_idx);
      // Only the first clk100 cycle of a CPU write is a request
      w_wr_req = cpu_we & cpu_phase;
      w_push   = w_wr_req & ~w_full;
      w_drop   = w_wr_req &  w_full;
      w_pop    = rd_en & ~w_empty;
      w_head   = r_mem[w_rd_idx];
   end

   // Storage write; suppressed during reset so a reset-cycle push is inert
   always_ff @(posedge clk100) begin
      if (w_push && !reset) begin
         r_mem[w_wr_idx] <= {cpu_addr, cpu_data};
      end
   end

   // Write pointer
   always_ff @(posedge clk100) begin
      if (reset) begin
         r_wr_ptr <= '0;
      end else if (w_push) begin
         r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
   end

   // Read pointer
   always_ff @(posedge clk100) begin
      if (reset) begin
         r_rd_ptr <= '0;
      end else if (w_pop) begin
         r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
   end

   // Registered head: popped entry appears the cycle after rd_en and holds
   always_ff @(posedge clk100) begin
      if (reset) begin
         r_rd_addr <= '0;
         r_rd_data <= '0;
      end else if (w_pop) begin
         r_rd_addr <= w_head[ENTRY_W-1:DATA_W];
         r_rd_data <= w_head[DATA_W-1:0];
      end
   end

   // Sticky overflow; a same-cycle drop overrides the clear
   always_ff @(posedge clk100) begin
      if (reset) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (overflow_clr) begin
         r_overflow <= 1'b0;
      end
   end

`ifdef SRAM_WRFIFO_DROPCNT_EN
   logic [CNT_W-1:0] r_drop_count;

   // Saturating drop counter; clear-plus-drop in one cycle leaves a count of 1
   always_ff @(posedge clk100) begin
      if (reset) begin
         r_drop_count <= '0;
      end else if (w_drop) begin
         if (overflow_clr) begin
            r_drop_count <= CNT_W'(1);
         end else if (r_drop_count != {CNT_W{1'b1}}) begin
            r_drop_count <= r_drop_count + CNT_W'(1);
         end
      end else if (overflow_clr) begin
         r_drop_count <= '0;
      end
   end

   assign drop_count = r_drop_count;
`else
   assign drop_count = CNT_W'(0);
`endif

   assign cpu_full = w_full;
   assign empty    = w_empty;
   assign level    = r_wr_ptr - r_rd_ptr;
   assign rd_addr  = r_rd_addr;
   assign rd_data  = r_rd_data;
   assign overflow = r_overflow;

endmodule

// File: tb/tb_sram_write_fifo.sv
// Directed testbench for sram_write_fifo (default DEPTH_LOG2 = 9).
module tb_sram_write_fifo;

   logic        clk100;
   logic        reset;
   logic        cpu_we;
   logic        cpu_phase;
   logic [16:0] cpu_addr;
   logic [7:0]  cpu_data;
   logic        cpu_full;
   logic        rd_en;
   logic [16:0] rd_addr;
   logic [7:0]  rd_data;
   logic        empty;
   logic [9:0]  level;
   logic        overflow;
   logic        overflow_clr;
   logic [15:0] drop_count;

   int n_checks = 0;
   int n_pass   = 0;

`ifdef SRAM_WRFIFO_DROPCNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   sram_write_fifo #(.DEPTH_LOG2(9)) dut (
      .clk100       (clk100),
      .reset        (reset),
      .cpu_we       (cpu_we),
      .cpu_phase    (cpu_phase),
      .cpu_addr     (cpu_addr),
      .cpu_data     (cpu_data),
      .cpu_full     (cpu_full),
      .rd_en        (rd_en),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .empty        (empty),
      .level        (level),
      .overflow     (overflow),
      .overflow_clr (overflow_clr),
      .drop_count   (drop_count)
   );

   initial clk100 = 1'b0;
   always #5 clk100 = ~clk100;

   function automatic logic [16:0] wrap_addr(input int k);
      return 17'h10000 + 17'(k);
   endfunction

   function automatic logic [7:0] wrap_data(input int k);
      return 8'(k) ^ 8'hA5;
   endfunction

   // Full 2-cycle CPU write; returns on the negedge after both cycles
   task automatic cpu_write(input logic [16:0] a, input logic [7:0] d, input logic clr);
      cpu_addr = a; cpu_data = d; cpu_we = 1'b1; cpu_phase = 1'b1; overflow_clr = clr;
      @(negedge clk100);
      cpu_phase = 1'b0; overflow_clr = 1'b0;
      @(negedge clk100);
      cpu_we = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(negedge clk100);
      @(negedge clk100);
      reset = 1'b0;
      n_checks++;
      if (level !== 10'd0 || empty !== 1'b1 || cpu_full !== 1'b0)
         $display("FAIL reset_status level=%0d empty=%b full=%b want 0/1/0", level, empty, cpu_full);
      else n_pass++;
      n_checks++;
      if (rd_addr !== 17'h0 || rd_data !== 8'h0 || overflow !== 1'b0 || drop_count !== 16'h0)
         $display("FAIL reset_regs addr=%h data=%h ovf=%b dc=%0d want 0", rd_addr, rd_data, overflow, drop_count);
      else n_pass++;
   endtask

   task automatic test_single();
      cpu_write(17'h1ABCD, 8'h5A, 1'b0);
      n_checks++;
      if (level !== 10'd1 || empty !== 1'b0)
         $display("FAIL single_push level=%0d empty=%b want 1/0", level, empty);
      else n_pass++;
      rd_en = 1'b1;
      @(negedge clk100);
      rd_en = 1'b0;
      n_checks++;
      if (rd_addr !== 17'h1ABCD || rd_data !== 8'h5A)
         $display("FAIL single_pop addr=%h data=%h want 1abcd/5a", rd_addr, rd_data);
      else n_pass++;
      n_checks++;
      if (empty !== 1'b1 || level !== 10'd0)
         $display("FAIL single_empty empty=%b level=%0d want 1/0", empty, level);
      else n_pass++;
   endtask

   task automatic test_empty_read();
      rd_en = 1'b1;
      @(negedge clk100);
      rd_en = 1'b0;
      n_checks++;
      if (rd_addr !== 17'h1ABCD || rd_data !== 8'h5A || level !== 10'd0 || empty !== 1'b1)
         $display("FAIL empty_read addr=%h data=%h level=%0d want 1abcd/5a/0", rd_addr, rd_data, level);
      else n_pass++;
   endtask

   task automatic test_fill_overflow();
      for (int i = 0; i < 512; i++) cpu_write(17'(i), 8'(i), 1'b0);
      n_checks++;
      if (cpu_full !== 1'b1 || level !== 10'd512 || overflow !== 1'b0)
         $display("FAIL fill full=%b level=%0d ovf=%b want 1/512/0", cpu_full, level, overflow);
      else n_pass++;
      cpu_write(17'h1FFFF, 8'hEE, 1'b0);
      n_checks++;
      if (overflow !== 1'b1 || level !== 10'd512 || drop_count !== (CNT_ON ? 16'd1 : 16'd0))
         $display("FAIL drop1 ovf=%b level=%0d dc=%0d want 1/512/%0d", overflow, level, drop_count, CNT_ON ? 1 : 0);
      else n_pass++;
      // Drop coinciding with overflow_clr: drop wins, count restarts at 1
      cpu_write(17'h1EEEE, 8'hDD, 1'b1);
      n_checks++;
      if (overflow !== 1'b1 || level !== 10'd512 || drop_count !== (CNT_ON ? 16'd1 : 16'd0))
         $display("FAIL drop_clr ovf=%b level=%0d dc=%0d want 1/512/%0d", overflow, level, drop_count, CNT_ON ? 1 : 0);
      else n_pass++;
   endtask

   task automatic test_full_push_pop();
      cpu_addr = 17'h1DDDD; cpu_data = 8'hCC;
      cpu_we = 1'b1; cpu_phase = 1'b1; rd_en = 1'b1;
      @(negedge clk100);
      cpu_phase = 1'b0; rd_en = 1'b0;
      n_checks++;
      if (level !== 10'd511 || overflow !== 1'b1 || cpu_full !== 1'b0 ||
          drop_count !== (CNT_ON ? 16'd2 : 16'd0))
         $display("FAIL full_pushpop level=%0d ovf=%b full=%b dc=%0d want 511/1/0/%0d",
                  level, overflow, cpu_full, drop_count, CNT_ON ? 2 : 0);
      else n_pass++;
      n_checks++;
      if (rd_addr !== 17'h0 || rd_data !== 8'h0)
         $display("FAIL full_pop_head addr=%h data=%h want 0/0", rd_addr, rd_data);
      else n_pass++;
      @(negedge clk100);
      cpu_we = 1'b0;
      n_checks++;
      if (level !== 10'd511)
         $display("FAIL second_half level=%0d want 511", level);
      else n_pass++;
   endtask

   task automatic test_overflow_clr();
      overflow_clr = 1'b1;
      @(negedge clk100);
      overflow_clr = 1'b0;
      n_checks++;
      if (overflow !== 1'b0 || drop_count !== 16'd0)
         $display("FAIL ovf_clr ovf=%b dc=%0d want 0/0", overflow, drop_count);
      else n_pass++;
   endtask

   task automatic test_drain();
      rd_en = 1'b1;
      for (int i = 1; i < 512; i++) begin
         @(negedge clk100);
         if (i == 511) rd_en = 1'b0;
         n_checks++;
         if (rd_addr !== 17'(i) || rd_data !== 8'(i))
            $display("FAIL drain_%0d addr=%h data=%h want %h/%h", i, rd_addr, rd_data, 17'(i), 8'(i));
         else n_pass++;
      end
      n_checks++;
      if (empty !== 1'b1 || level !== 10'd0)
         $display("FAIL drain_empty empty=%b level=%0d want 1/0", empty, level);
      else n_pass++;
   endtask

   task automatic test_back_to_back_wrap();
      for (int k = 0; k < 3; k++) begin
         cpu_addr = wrap_addr(k); cpu_data = wrap_data(k);
         cpu_we = 1'b1; cpu_phase = 1'b1;
         @(negedge clk100);
      end
      for (int j = 0; j < 520; j++) begin
         cpu_addr = wrap_addr(j + 3); cpu_data = wrap_data(j + 3);
         rd_en = 1'b1;
         @(negedge clk100);
         n_checks++;
         if (level !== 10'd3 || rd_addr !== wrap_addr(j) || rd_data !== wrap_data(j))
            $display("FAIL wrap_%0d level=%0d addr=%h data=%h want 3/%h/%h",
                     j, level, rd_addr, rd_data, wrap_addr(j), wrap_data(j));
         else n_pass++;
      end
      cpu_we = 1'b0; cpu_phase = 1'b0;
      for (int j = 520; j < 523; j++) begin
         @(negedge clk100);
         if (j == 522) rd_en = 1'b0;
         n_checks++;
         if (rd_addr !== wrap_addr(j) || rd_data !== wrap_data(j))
            $display("FAIL wrap_tail_%0d addr=%h data=%h want %h/%h",
                     j, rd_addr, rd_data, wrap_addr(j), wrap_data(j));
         else n_pass++;
      end
      n_checks++;
      if (empty !== 1'b1 || level !== 10'd0)
         $display("FAIL wrap_empty empty=%b level=%0d want 1/0", empty, level);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 100; k++) begin
         cpu_addr = 17'(k); cpu_data = 8'(k);
         cpu_we = 1'b1; cpu_phase = 1'b1;
         @(negedge clk100);
      end
      cpu_we = 1'b0; cpu_phase = 1'b0;
      n_checks++;
      if (level !== 10'd100 || rd_data !== 8'hAF)
         $display("FAIL pre_reset level=%0d data=%h want 100/af", level, rd_data);
      else n_pass++;
      reset = 1'b1; cpu_we = 1'b1; cpu_phase = 1'b1; rd_en = 1'b1;
      @(negedge clk100);
      reset = 1'b0; cpu_we = 1'b0; cpu_phase = 1'b0; rd_en = 1'b0;
      n_checks++;
      if (level !== 10'd0 || empty !== 1'b1 || cpu_full !== 1'b0)
         $display("FAIL mid_reset_status level=%0d empty=%b full=%b want 0/1/0", level, empty, cpu_full);
      else n_pass++;
      n_checks++;
      if (rd_data !== 8'h0 || rd_addr !== 17'h0 || overflow !== 1'b0 || drop_count !== 16'h0)
         $display("FAIL mid_reset_regs addr=%h data=%h ovf=%b dc=%0d want 0", rd_addr, rd_data, overflow, drop_count);
      else n_pass++;
      rd_en = 1'b1;
      @(negedge clk100);
      rd_en = 1'b0;
      n_checks++;
      if (level !== 10'd0 || empty !== 1'b1 || rd_data !== 8'h0)
         $display("FAIL post_reset_read level=%0d empty=%b data=%h want 0/1/0", level, empty, rd_data);
      else n_pass++;
   endtask

   initial begin
      reset = 1'b1; cpu_we = 1'b0; cpu_phase = 1'b0; cpu_addr = '0; cpu_data = '0;
      rd_en = 1'b0; overflow_clr = 1'b0;
      @(negedge clk100);
      test_reset();
      test_single();
      test_empty_read();
      test_fill_overflow();
      test_full_push_pop();
      test_overflow_clr();
      test_drain();
      test_back_to_back_wrap();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
